// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI-to-pixel bridge.
package spi_bridge_pkg;

  localparam int unsigned DEF_WORD_SIZE = 8;
  localparam int unsigned PIX_W         = 3 * DEF_WORD_SIZE;

  typedef enum logic [1:0] {
    WAIT_R,
    WAIT_G,
    WAIT_B
  } chan_state_t;

endpackage

// File: rtl/spi_pixel_bridge_fifo.sv
// Show-ahead synchronous FIFO; a write while full succeeds only alongside a read.
module sync_fifo
  import spi_bridge_pkg::*;
#(
  parameter int unsigned WIDTH = PIX_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full_o    = (count == (AW+1)'(DEPTH));
  assign empty_o   = (count == '0);
  assign do_rd     = rd_en_i && !empty_o;
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign rd_data_o = empty_o ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_pixel_bridge.sv
// Synchronizes SPI word strobes into clk, packs R/G/B words into pixels and buffers them.
module spi_pixel_bridge
  import spi_bridge_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = DEF_WORD_SIZE,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   nreset_i,
  input  logic                   cs_i,
  input  logic                   rxtx_done_i,
  input  logic [WORD_SIZE-1:0]   data_rx_i,
  output logic [3*WORD_SIZE-1:0] pixel_o,
  output logic                   pixel_valid_o,
  input  logic                   pixel_ready_i,
  input  logic [WORD_SIZE-1:0]   tx_data_i,
  input  logic                   tx_load_i,
  output logic [WORD_SIZE-1:0]   data_tx_o,
  output logic                   frame_active_o,
  output logic                   overflow_o
);

  localparam int unsigned PW = 3 * WORD_SIZE;

  logic [SYNC_STAGES-1:0] done_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   done_prev;
  logic                   cs_prev;
  logic                   done_s;
  logic                   cs_s;
  logic                   done_pulse;
  logic                   frame_end;
  logic                   accept;

  chan_state_t            state;
  chan_state_t            state_nx;
  logic                   r_load;
  logic                   g_load;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [WORD_SIZE-1:0]   r_q;
  logic [WORD_SIZE-1:0]   g_q;
  logic [WORD_SIZE-1:0]   tx_q;
  logic                   overflow_q;

  // cs chain resets high so the frame reads as inactive straight out of reset
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      done_sync <= '0;
      cs_sync   <= '1;
      done_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      done_sync <= {done_sync[SYNC_STAGES-2:0], rxtx_done_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_i};
      done_prev <= done_s;
      cs_prev   <= cs_s;
    end
  end

  assign done_s     = done_sync[SYNC_STAGES-1];
  assign cs_s       = cs_sync[SYNC_STAGES-1];
  assign done_pulse = done_s && !done_prev;
  assign frame_end  = cs_s && !cs_prev;
  // frame end implies cs_s high, so a coincident word is already rejected here
  assign accept     = done_pulse && !cs_s;

  always_ff @(posedge clk_i) begin
    if (!nreset_i) state <= WAIT_R;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (frame_end) begin
      state_nx = WAIT_R;
    end else if (accept) begin
      case (state)
        WAIT_R:  state_nx = WAIT_G;
        WAIT_G:  state_nx = WAIT_B;
        default: state_nx = WAIT_R;
      endcase
    end
  end

  always_comb begin
    r_load = 1'b0;
    g_load = 1'b0;
    push   = 1'b0;
    if (accept) begin
      case (state)
        WAIT_R:  r_load = 1'b1;
        WAIT_G:  g_load = 1'b1;
        WAIT_B:  push   = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      r_q        <= '0;
      g_q        <= '0;
      tx_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (r_load)    r_q  <= data_rx_i;
      if (g_load)    g_q  <= data_rx_i;
      if (tx_load_i) tx_q <= tx_data_i;
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  assign pop = !fifo_empty && pixel_ready_i;

  sync_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .nreset_i  (nreset_i),
    .wr_en_i   (push),
    .wr_data_i ({r_q, g_q, data_rx_i}),
    .rd_en_i   (pixel_ready_i),
    .rd_data_o (pixel_o),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign pixel_valid_o  = !fifo_empty;
  assign data_tx_o      = tx_q;
  assign frame_active_o = !cs_s;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_spi_pixel_bridge.sv
// Directed self-checking bench for spi_pixel_bridge.
module tb_spi_pixel_bridge;

  logic        clk = 1'b0;
  logic        nreset_i;
  logic        cs_i;
  logic        rxtx_done_i;
  logic [7:0]  data_rx_i;
  logic [23:0] pixel_o;
  logic        pixel_valid_o;
  logic        pixel_ready_i;
  logic [7:0]  tx_data_i;
  logic        tx_load_i;
  logic [7:0]  data_tx_o;
  logic        frame_active_o;
  logic        overflow_o;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  spi_pixel_bridge #(
    .WORD_SIZE   (8),
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i          (clk),
    .nreset_i       (nreset_i),
    .cs_i           (cs_i),
    .rxtx_done_i    (rxtx_done_i),
    .data_rx_i      (data_rx_i),
    .pixel_o        (pixel_o),
    .pixel_valid_o  (pixel_valid_o),
    .pixel_ready_i  (pixel_ready_i),
    .tx_data_i      (tx_data_i),
    .tx_load_i      (tx_load_i),
    .data_tx_o      (data_tx_o),
    .frame_active_o (frame_active_o),
    .overflow_o     (overflow_o)
  );

  task automatic do_reset();
    @(negedge clk);
    nreset_i = 1'b0;
    repeat (3) @(negedge clk);
    nreset_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w);
    @(negedge clk);
    data_rx_i   = w;
    rxtx_done_i = 1'b1;
    repeat (6) @(negedge clk);
    rxtx_done_i = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_pixel(input logic [23:0] p);
    send_word(p[23:16]);
    send_word(p[15:8]);
    send_word(p[7:0]);
  endtask

  task automatic frame_start();
    @(negedge clk);
    cs_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_stop();
    @(negedge clk);
    cs_i = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_one();
    pixel_ready_i = 1'b1;
    @(negedge clk);
    pixel_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    nreset_i = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({pixel_o, pixel_valid_o, data_tx_o, frame_active_o, overflow_o} !== 35'd0) begin
      fails++;
      $display("FAIL reset_outputs: got pix=%h v=%b tx=%h fa=%b ovf=%b, want all 0",
               pixel_o, pixel_valid_o, data_tx_o, frame_active_o, overflow_o);
    end
    nreset_i = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (frame_active_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_frame_idle: got %b want 0", frame_active_o);
    end
  endtask

  task automatic test_frame_active();
    @(negedge clk);
    cs_i = 1'b0;
    @(negedge clk);
    tests++;
    if (frame_active_o !== 1'b0) begin
      fails++;
      $display("FAIL cs_sync_early: got %b want 0", frame_active_o);
    end
    @(negedge clk);
    tests++;
    if (frame_active_o !== 1'b1) begin
      fails++;
      $display("FAIL cs_sync_latency: got %b want 1", frame_active_o);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    send_word(8'h12);
    send_word(8'h34);
    @(negedge clk);
    data_rx_i   = 8'h56;
    rxtx_done_i = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (pixel_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL basic_valid_early: got %b want 0", pixel_valid_o);
    end
    @(negedge clk);
    tests++;
    if (pixel_valid_o !== 1'b1 || pixel_o !== 24'h123456) begin
      fails++;
      $display("FAIL basic_pixel: got v=%b pix=%h want v=1 pix=123456", pixel_valid_o, pixel_o);
    end
    repeat (3) @(negedge clk);
    rxtx_done_i = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    if (overflow_o !== 1'b0 || pixel_o !== 24'h123456) begin
      fails++;
      $display("FAIL basic_hold: got ovf=%b pix=%h want ovf=0 pix=123456", overflow_o, pixel_o);
    end
    pop_one();
    tests++;
    if (pixel_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL basic_drain: got v=%b want 0", pixel_valid_o);
    end
  endtask

  task automatic test_overflow();
    logic [23:0] exp;
    for (int i = 0; i < 5; i++) send_pixel({8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i)});
    tests++;
    if (overflow_o !== 1'b1) begin
      fails++;
      $display("FAIL ovf_flag: got %b want 1", overflow_o);
    end
    for (int i = 0; i < 4; i++) begin
      exp = {8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i)};
      tests++;
      if (pixel_valid_o !== 1'b1 || pixel_o !== exp) begin
        fails++;
        $display("FAIL ovf_drain%0d: got v=%b pix=%h want v=1 pix=%h", i, pixel_valid_o, pixel_o, exp);
      end
      pop_one();
    end
    tests++;
    if (pixel_valid_o !== 1'b0 || overflow_o !== 1'b1) begin
      fails++;
      $display("FAIL ovf_empty: got v=%b ovf=%b want v=0 ovf=1", pixel_valid_o, overflow_o);
    end
  endtask

  task automatic test_push_pop_full();
    logic [23:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) send_pixel({8'h40 + 8'(i), 8'h50 + 8'(i), 8'h60 + 8'(i)});
    send_word(8'h44);
    send_word(8'h54);
    @(negedge clk);
    data_rx_i   = 8'h64;
    rxtx_done_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pixel_ready_i = 1'b1;
    @(negedge clk);
    pixel_ready_i = 1'b0;
    tests++;
    if (overflow_o !== 1'b0 || pixel_valid_o !== 1'b1 || pixel_o !== 24'h415161) begin
      fails++;
      $display("FAIL pp_full: got ovf=%b v=%b pix=%h want ovf=0 v=1 pix=415161",
               overflow_o, pixel_valid_o, pixel_o);
    end
    repeat (3) @(negedge clk);
    rxtx_done_i = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 1; i < 5; i++) begin
      exp = {8'h40 + 8'(i), 8'h50 + 8'(i), 8'h60 + 8'(i)};
      tests++;
      if (pixel_valid_o !== 1'b1 || pixel_o !== exp) begin
        fails++;
        $display("FAIL pp_drain%0d: got v=%b pix=%h want v=1 pix=%h", i, pixel_valid_o, pixel_o, exp);
      end
      pop_one();
    end
    tests++;
    if (pixel_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL pp_empty: got v=%b want 0", pixel_valid_o);
    end
  endtask

  task automatic test_frame_abort();
    send_word(8'hAA);
    send_word(8'hBB);
    frame_stop();
    frame_start();
    send_pixel(24'h010203);
    tests++;
    if (pixel_valid_o !== 1'b1 || pixel_o !== 24'h010203) begin
      fails++;
      $display("FAIL abort_pixel: got v=%b pix=%h want v=1 pix=010203", pixel_valid_o, pixel_o);
    end
    pop_one();
    tests++;
    if (pixel_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL abort_single: got v=%b want 0", pixel_valid_o);
    end
  endtask

  task automatic test_cs_high();
    frame_stop();
    send_word(8'hE1);
    send_word(8'hE2);
    send_word(8'hE3);
    tests++;
    if (pixel_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL cs_high_nopix: got v=%b want 0", pixel_valid_o);
    end
    frame_start();
    send_pixel(24'h445566);
    tests++;
    if (pixel_valid_o !== 1'b1 || pixel_o !== 24'h445566) begin
      fails++;
      $display("FAIL cs_high_state: got v=%b pix=%h want v=1 pix=445566", pixel_valid_o, pixel_o);
    end
    pop_one();
  endtask

  task automatic test_tx_and_reset();
    tx_data_i = 8'h5A;
    tx_load_i = 1'b1;
    @(negedge clk);
    tx_load_i = 1'b0;
    tx_data_i = 8'h00;
    tests++;
    if (data_tx_o !== 8'h5A) begin
      fails++;
      $display("FAIL tx_load: got %h want 5a", data_tx_o);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (data_tx_o !== 8'h5A) begin
      fails++;
      $display("FAIL tx_hold: got %h want 5a", data_tx_o);
    end
    send_pixel(24'h0A0B0C);
    send_word(8'h11);
    nreset_i = 1'b0;
    @(negedge clk);
    tests++;
    if ({pixel_o, pixel_valid_o, data_tx_o, frame_active_o, overflow_o} !== 35'd0) begin
      fails++;
      $display("FAIL midreset_outputs: got pix=%h v=%b tx=%h fa=%b ovf=%b, want all 0",
               pixel_o, pixel_valid_o, data_tx_o, frame_active_o, overflow_o);
    end
    nreset_i = 1'b1;
    repeat (4) @(negedge clk);
    send_pixel(24'h223344);
    tests++;
    if (pixel_valid_o !== 1'b1 || pixel_o !== 24'h223344) begin
      fails++;
      $display("FAIL midreset_fsm: got v=%b pix=%h want v=1 pix=223344", pixel_valid_o, pixel_o);
    end
  endtask

  initial begin
    nreset_i      = 1'b1;
    cs_i          = 1'b1;
    rxtx_done_i   = 1'b0;
    data_rx_i     = '0;
    pixel_ready_i = 1'b0;
    tx_data_i     = '0;
    tx_load_i     = 1'b0;
    test_reset();
    test_frame_active();
    test_basic();
    test_overflow();
    test_push_pop_full();
    test_frame_abort();
    test_cs_high();
    test_tx_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
